dffrs_init_seq: RTL and testbench



---
 rtl/dffrs_init_seq.sv | 90 +++++++++
 tb/tb_dffrs_init_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dffrs_init_seq.sv
// Timed async clear/preset sequencer: force-loads a pattern into a DFFRS bank through
// its RN/SN pins, holding the pulse width and recovery time before re-enabling the clock.
module dffrs_init_seq #(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2,
    parameter int RECOV_CYC = 2
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] rn_out,
    output logic [WIDTH-1:0] sn_out,
    output logic             clk_en,
    output logic             busy,
    output logic             done
);

    localparam int MAX_CYC = (PULSE_CYC > RECOV_CYC) ? PULSE_CYC : RECOV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        RELEASE,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Pins are computed as next-state values so every output comes straight from a flop.
    // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state  <= IDLE;
            cnt    <= '0;
            rn_out <= '1;
            sn_out <= '1;
            clk_en <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    rn_out <= '1;
                    sn_out <= '1;
                    clk_en <= 1'b1;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    if (start) begin
                        state  <= ASSERT;
                        cnt    <= CNT_W'(PULSE_CYC);
                        clk_en <= 1'b0;
                        busy   <= 1'b1;
                        // A masked bit drives exactly one of its two pins low, never both.
                        rn_out <= ~(mask & ~pattern);
                        sn_out <= ~(mask & pattern);
                    end else begin
                        state <= IDLE;
                    end
                end
                ASSERT: begin
                    if (cnt == CNT_W'(1)) begin
                        state  <= RELEASE;
                        cnt    <= CNT_W'(RECOV_CYC);
                        rn_out <= '1;
                        sn_out <= '1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == CNT_W'(1)) begin
                        state  <= DONE;
                        cnt    <= '0;
                        clk_en <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dffrs_init_seq.sv
// Self-checking bench for dffrs_init_seq: random and directed loads compared against a
// cycle-position model of the force/recover timeline.
module tb_dffrs_init_seq;

    localparam int W = 8;
    localparam int P = 2;
    localparam int R = 3;

    logic         CK = 1'b0;
    logic         RN = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] pattern = '0;
    logic [W-1:0] mask = '0;
    logic [W-1:0] rn_out;
    logic [W-1:0] sn_out;
    logic         clk_en;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pos = cycles since the accepting edge (-1 when idle).
    int           pos = -1;
    logic [W-1:0] cap_pat = '0;
    logic [W-1:0] cap_mask = '0;

    dffrs_init_seq #(.WIDTH(W), .PULSE_CYC(P), .RECOV_CYC(R)) dut (
        .CK(CK), .RN(RN), .start(start), .pattern(pattern), .mask(mask),
        .rn_out(rn_out), .sn_out(sn_out), .clk_en(clk_en), .busy(busy), .done(done)
    );

    always #5 CK = ~CK;

    function automatic logic [2*W+2:0] expected();
        logic [W-1:0] rn_e;
        logic [W-1:0] sn_e;
        logic ce, b, d;
        rn_e = '1; sn_e = '1; ce = 1'b1; b = 1'b0; d = 1'b0;
        if (pos >= 0 && pos < P) begin
            for (int i = 0; i < W; i++)
                if (cap_mask[i]) begin
                    if (cap_pat[i]) sn_e[i] = 1'b0;
                    else            rn_e[i] = 1'b0;
                end
            ce = 1'b0; b = 1'b1;
        end else if (pos >= P && pos < P + R) begin
            ce = 1'b0; b = 1'b1;
        end else if (pos == P + R) begin
            d = 1'b1;
        end
        return {rn_e, sn_e, ce, b, d};
    endfunction

    function automatic logic [2*W+2:0] observed();
        return {rn_out, sn_out, clk_en, busy, done};
    endfunction

    // Called at a falling edge; applies inputs, advances one rising edge, returns at the next falling edge.
    task automatic step(input logic s, input logic [W-1:0] p, input logic [W-1:0] m);
        start = s; pattern = p; mask = m;
        @(posedge CK);
        if (pos == -1 || pos == P + R) begin
            if (s) begin
                pos = 0; cap_pat = p; cap_mask = m;
            end else begin
                pos = -1;
            end
        end else begin
            pos++;
        end
        @(negedge CK);
    endtask

    task automatic drain();
        repeat (8) step(1'b0, W'($urandom), W'($urandom));
    endtask

    task automatic test_reset();
        #2 RN = 1'b0;
        #1;
        n_checks++;
        if (observed() !== {{W{1'b1}}, {W{1'b1}}, 3'b100}) begin
            n_fail++; $display("FAIL reset_values: got %h expected %h", observed(), {{W{1'b1}}, {W{1'b1}}, 3'b100});
        end
        @(negedge CK);
        RN = 1'b1;
        step(1'b0, '0, '0);
        n_checks++;
        if (observed() !== expected()) begin
            n_fail++; $display("FAIL reset_idle: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_basic_load();
        int sn_cnt, rn_cnt, ce_lo, done_edge;
        sn_cnt = 0; rn_cnt = 0; ce_lo = 0; done_edge = -1;
        for (int k = 1; k <= 9; k++) begin
            step(k == 1, 8'hA5, 8'hFF);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL basic_step%0d: got %h expected %h", k, observed(), expected());
            end
            if (sn_out == 8'h5A) sn_cnt++;
            if (rn_out == 8'hA5) rn_cnt++;
            if (!clk_en) ce_lo++;
            if (done && done_edge < 0) done_edge = k;
        end
        n_checks++;
        if (sn_cnt != P || rn_cnt != P) begin
            n_fail++; $display("FAIL basic_pulse_width: got sn %0d rn %0d cycles expected %0d", sn_cnt, rn_cnt, P);
        end
        n_checks++;
        if (ce_lo != P + R) begin
            n_fail++; $display("FAIL basic_clk_en_low: got %0d cycles expected %0d", ce_lo, P + R);
        end
        n_checks++;
        if (done_edge != P + R + 1) begin
            n_fail++; $display("FAIL basic_latency: got %0d edges expected %0d", done_edge, P + R + 1);
        end
    endtask

    task automatic test_masked_load();
        int f0_cnt, bad;
        f0_cnt = 0; bad = 0;
        for (int k = 1; k <= 8; k++) begin
            step(k == 1, 8'hFF, 8'h0F);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL masked_step%0d: got %h expected %h", k, observed(), expected());
            end
            if (sn_out == 8'hF0) f0_cnt++;
            if (rn_out != 8'hFF || sn_out[7:4] != 4'hF) bad++;
        end
        n_checks++;
        if (f0_cnt != P || bad != 0) begin
            n_fail++; $display("FAIL masked_pins: got %0d cycles of F0 and %0d bad cycles expected %0d and 0", f0_cnt, bad, P);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] next_pat;
        int dones;
        next_pat = 8'h00; dones = 0;
        for (int k = 1; k <= 3 * (P + R + 1); k++) begin
            if (pos == -1 || pos == P + R) begin
                step(1'b1, next_pat, 8'hFF);
                next_pat = ~next_pat;
            end else begin
                step(1'b1, W'($urandom), W'($urandom));
            end
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL b2b_step%0d: got %h expected %h", k, observed(), expected());
            end
            n_checks++;
            if ((~rn_out & ~sn_out) !== '0) begin
                n_fail++; $display("FAIL b2b_invariant: got rn %h sn %h expected no common low bit", rn_out, sn_out);
            end
            if (done) dones++;
        end
        n_checks++;
        if (dones != 3) begin
            n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", dones);
        end
        drain();
    endtask

    task automatic test_async_reset();
        step(1'b1, 8'h00, 8'hFF);
        n_checks++;
        if (rn_out !== 8'h00) begin
            n_fail++; $display("FAIL areset_asserted: got rn %h expected 00", rn_out);
        end
        RN = 1'b0;
        #1;
        n_checks++;
        if (observed() !== {{W{1'b1}}, {W{1'b1}}, 3'b100}) begin
            n_fail++; $display("FAIL areset_immediate: got %h expected %h", observed(), {{W{1'b1}}, {W{1'b1}}, 3'b100});
        end
        pos = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CK);
            n_checks++;
            if (done !== 1'b0 || clk_en !== 1'b1) begin
                n_fail++; $display("FAIL areset_hold: got done %b clk_en %b expected 0 1", done, clk_en);
            end
        end
        RN = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(k == 3, 8'h3C, 8'hFF);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL areset_after_step%0d: got %h expected %h", k, observed(), expected());
            end
        end
    endtask

    task automatic test_mid_changes();
        logic [W-1:0] p_seq [9];
        logic [W-1:0] m_seq [9];
        logic         s_seq [9];
        p_seq = '{8'h00, 8'hFF, 8'h5A, 8'hFF, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00};
        m_seq = '{8'hFF, 8'h0F, 8'hF0, 8'hFF, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00};
        s_seq = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
        for (int k = 0; k < 9; k++) begin
            step(s_seq[k], p_seq[k], m_seq[k]);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL midchange_step%0d: got %h expected %h", k, observed(), expected());
            end
        end
    endtask

    task automatic test_zero_mask();
        int busy_cnt, ce_lo, dones, bad;
        busy_cnt = 0; ce_lo = 0; dones = 0; bad = 0;
        for (int k = 1; k <= 8; k++) begin
            step(k == 1, 8'hAB, 8'h00);
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL zeromask_step%0d: got %h expected %h", k, observed(), expected());
            end
            if (busy) busy_cnt++;
            if (!clk_en) ce_lo++;
            if (done) dones++;
            if (rn_out != '1 || sn_out != '1) bad++;
        end
        n_checks++;
        if (busy_cnt != P + R || ce_lo != P + R || dones != 1 || bad != 0) begin
            n_fail++; $display("FAIL zeromask_summary: got busy %0d clk_en_low %0d done %0d bad %0d expected %0d %0d 1 0",
                               busy_cnt, ce_lo, dones, bad, P + R, P + R);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 2) == 0, W'($urandom), W'($urandom));
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL random_step%0d: got %h expected %h", k, observed(), expected());
            end
            n_checks++;
            if ((~rn_out & ~sn_out) !== '0) begin
                n_fail++; $display("FAIL random_invariant: got rn %h sn %h expected no common low bit", rn_out, sn_out);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_masked_load();
        test_back_to_back();
        test_async_reset();
        test_mid_changes();
        test_zero_mask();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
